// File: rtl/ip_stack_pkg.sv
// Shared IPv4 stack definitions used by both the receive and transmit datapaths.
package ip_stack_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_VERSION_IHL    = 8'h45;
    localparam logic [47:0] MAC_BROADCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] CHECKSUM_GOOD     = 16'hFFFF;

    localparam logic [7:0]  ETH_HDR_BYTES     = 8'd14;
    localparam logic [7:0]  IP_HDR_BYTES      = 8'd20;
    localparam logic [7:0]  MIN_PAYLOAD_BYTES = 8'd2;

    // Byte offsets inside each header
    localparam logic [7:0]  ETH_SRC_MAC_OFS   = 8'd6;
    localparam logic [7:0]  ETH_TYPE_OFS      = 8'd12;
    localparam logic [7:0]  IP_SRC_OFS        = 8'd12;
    localparam logic [7:0]  IP_DST_OFS        = 8'd16;

    typedef enum logic [2:0] {
        RX_ETH_HDR,
        RX_IP_HDR,
        RX_USER_DATA,
        DROP,
        HOLD
    } rx_state_t;

    function automatic logic [7:0] last_index(input logic [7:0] size);
        return size - 8'd1;
    endfunction

endpackage

// File: rtl/counter_sync_reset.sv
// Saturating up-counter with a synchronous clear that takes priority over enable.
module counter_sync_reset #(
    parameter int WIDTH = 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses <= so every flop samples values from before the edge.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ipv4_checksum_accumulator.sv
// Ones-complement byte-wise accumulator for the IPv4 header checksum; sum includes the current byte.
module ipv4_checksum_accumulator (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  byte_in,
    input  logic        high_sel,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [15:0] addend;
    logic [16:0] add_full;
    logic [15:0] folded;

    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    always_comb begin
        addend   = high_sel ? {byte_in, 8'h00} : {8'h00, byte_in};
        add_full = {1'b0, acc} + {1'b0, addend};
        // End-around carry; cannot carry again since addend is at most 0xFF00
        folded   = add_full[15:0] + {15'd0, add_full[16]};
    end

    assign sum = enable ? folded : acc;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/ip_packet_rx.sv
// Ethernet/IPv4 frame receiver: filters frames addressed to the accelerator and
// delivers a 10-bit message from the first two payload bytes.
module ip_packet_rx
    import ip_stack_pkg::*;
#(
    parameter int AXI_S_DATA_WIDTH = 8,
    parameter int IP_ADDR_WIDTH    = 32,
    parameter int MAC_ADDR_WIDTH   = 48,
    parameter int ACCEL_DATA_WIDTH = 10
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [IP_ADDR_WIDTH-1:0]    ACCELERATOR_IP_ADDRESS,
    input  logic [MAC_ADDR_WIDTH-1:0]   ACCELERATOR_MAC_ADDRESS,
    input  logic [AXI_S_DATA_WIDTH-1:0] MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    output logic                        MAC_DATA_READY,
    input  logic                        MAC_DATA_LAST,
    input  logic                        MAC_DATA_TUSER,
    output logic [IP_ADDR_WIDTH-1:0]    SENDER_IP_ADDRESS,
    output logic [MAC_ADDR_WIDTH-1:0]   SENDER_MAC_ADDRESS,
    output logic [ACCEL_DATA_WIDTH-1:0] RECEIVED_MESSAGE,
    output logic                        MESSAGE_VALID,
    input  logic                        MESSAGE_ACK
);

    localparam int MSG_HI_BITS = ACCEL_DATA_WIDTH - AXI_S_DATA_WIDTH;

    rx_state_t state;
    rx_state_t state_next;

    logic                        beat;
    logic                        commit;
    logic                        restart;
    logic [7:0]                  byte_cnt;
    logic [15:0]                 cks_sum;
    logic                        in_ip_hdr;
    logic                        eth_ok;
    logic                        ip_ok;

    logic [MAC_ADDR_WIDTH-1:0]   dst_mac_r;
    logic [MAC_ADDR_WIDTH-1:0]   src_mac_r;
    logic [IP_ADDR_WIDTH-1:0]    src_ip_r;
    logic [IP_ADDR_WIDTH-1:0]    dst_ip_r;
    logic [AXI_S_DATA_WIDTH-1:0] type_hi_r;
    logic [AXI_S_DATA_WIDTH-1:0] pay0_r;
    logic [AXI_S_DATA_WIDTH-1:0] pay1_r;
    logic                        ver_ok_r;
    logic [AXI_S_DATA_WIDTH-1:0] msg_low;

    assign MAC_DATA_READY = (state != HOLD);
    assign MESSAGE_VALID  = (state == HOLD);
    assign beat           = MAC_DATA_VALID && MAC_DATA_READY;
    assign in_ip_hdr      = (state == RX_IP_HDR);

    // A LAST beat ends the frame even when the state does not change
    assign restart = (state_next != state) || (beat && MAC_DATA_LAST);

    counter_sync_reset #(
        .WIDTH (8)
    ) u_byte_cnt (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clear  (restart),
        .enable (beat),
        .count  (byte_cnt)
    );

    ipv4_checksum_accumulator u_cks (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .clear    (!in_ip_hdr),
        .enable   (beat && in_ip_hdr),
        .byte_in  (MAC_DATA_IN),
        .high_sel (!byte_cnt[0]),
        .sum      (cks_sum)
    );

    // Evaluated on the final header byte, which is still on MAC_DATA_IN
    assign eth_ok = ((dst_mac_r == ACCELERATOR_MAC_ADDRESS) || (dst_mac_r == MAC_BROADCAST))
                 && ({type_hi_r, MAC_DATA_IN} == ETHERTYPE_IPV4);

    assign ip_ok  = ver_ok_r
                 && ({dst_ip_r[IP_ADDR_WIDTH-AXI_S_DATA_WIDTH-1:0], MAC_DATA_IN} == ACCELERATOR_IP_ADDRESS)
                 && (cks_sum == CHECKSUM_GOOD);

    assign msg_low = (byte_cnt == 8'd1) ? MAC_DATA_IN : pay1_r;

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state <= RX_ETH_HDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        commit     = 1'b0;
        case (state)
            RX_ETH_HDR: begin
                if (beat && !MAC_DATA_LAST && (byte_cnt == last_index(ETH_HDR_BYTES))) begin
                    state_next = eth_ok ? RX_IP_HDR : DROP;
                end
            end
            RX_IP_HDR: begin
                if (beat) begin
                    if (MAC_DATA_LAST) begin
                        state_next = RX_ETH_HDR;
                    end else if (byte_cnt == last_index(IP_HDR_BYTES)) begin
                        state_next = ip_ok ? RX_USER_DATA : DROP;
                    end
                end
            end
            RX_USER_DATA: begin
                if (beat && MAC_DATA_LAST) begin
                    if (!MAC_DATA_TUSER && (byte_cnt >= last_index(MIN_PAYLOAD_BYTES))) begin
                        commit     = 1'b1;
                        state_next = HOLD;
                    end else begin
                        state_next = RX_ETH_HDR;
                    end
                end
            end
            DROP: begin
                if (beat && MAC_DATA_LAST) begin
                    state_next = RX_ETH_HDR;
                end
            end
            HOLD: begin
                if (MESSAGE_ACK) begin
                    state_next = RX_ETH_HDR;
                end
            end
            default: state_next = RX_ETH_HDR;
        endcase
    end

    // Header field capture; shift registers fill MSB-first as bytes arrive
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            dst_mac_r <= '0;
            src_mac_r <= '0;
            src_ip_r  <= '0;
            dst_ip_r  <= '0;
            type_hi_r <= '0;
            pay0_r    <= '0;
            pay1_r    <= '0;
            ver_ok_r  <= 1'b0;
        end else if (beat) begin
            case (state)
                RX_ETH_HDR: begin
                    if (byte_cnt < ETH_SRC_MAC_OFS) begin
                        dst_mac_r <= {dst_mac_r[MAC_ADDR_WIDTH-AXI_S_DATA_WIDTH-1:0], MAC_DATA_IN};
                    end else if (byte_cnt < ETH_TYPE_OFS) begin
                        src_mac_r <= {src_mac_r[MAC_ADDR_WIDTH-AXI_S_DATA_WIDTH-1:0], MAC_DATA_IN};
                    end else if (byte_cnt == ETH_TYPE_OFS) begin
                        type_hi_r <= MAC_DATA_IN;
                    end
                end
                RX_IP_HDR: begin
                    if (byte_cnt == 8'd0) begin
                        ver_ok_r <= (MAC_DATA_IN == IP_VERSION_IHL);
                    end else if ((byte_cnt >= IP_SRC_OFS) && (byte_cnt < IP_DST_OFS)) begin
                        src_ip_r <= {src_ip_r[IP_ADDR_WIDTH-AXI_S_DATA_WIDTH-1:0], MAC_DATA_IN};
                    end else if (byte_cnt >= IP_DST_OFS) begin
                        dst_ip_r <= {dst_ip_r[IP_ADDR_WIDTH-AXI_S_DATA_WIDTH-1:0], MAC_DATA_IN};
                    end
                end
                RX_USER_DATA: begin
                    if (byte_cnt == 8'd0) begin
                        pay0_r <= MAC_DATA_IN;
                    end else if (byte_cnt == 8'd1) begin
                        pay1_r <= MAC_DATA_IN;
                    end
                end
                default: ;
            endcase
        end
    end

    // Delivered outputs move only on commit, so they stay stable throughout HOLD
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            SENDER_IP_ADDRESS  <= '0;
            SENDER_MAC_ADDRESS <= '0;
            RECEIVED_MESSAGE   <= '0;
        end else if (commit) begin
            SENDER_IP_ADDRESS  <= src_ip_r;
            SENDER_MAC_ADDRESS <= src_mac_r;
            RECEIVED_MESSAGE   <= {pay0_r[MSG_HI_BITS-1:0], msg_low};
        end
    end

endmodule

// File: tb/tb_ip_packet_rx.sv
// Self-checking bench for ip_packet_rx: directed scenarios plus randomized frames
// checked against a frame-level acceptance model.
module tb_ip_packet_rx;

    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_02;
    localparam logic [31:0] LOCAL_IP  = 32'h0A00_0002;
    localparam logic [47:0] PEER_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [31:0] PEER_IP   = 32'h0A00_0001;
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_READY;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_TUSER;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [9:0]  RECEIVED_MESSAGE;
    logic        MESSAGE_VALID;
    logic        MESSAGE_ACK;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_ip;
    logic [47:0] exp_mac;
    logic [9:0]  exp_msg;

    int          kind;
    int          flen;
    logic        ftuser;
    logic [47:0] r_dmac;
    logic [31:0] r_dip;

    always #5 ACLK = ~ACLK;

    ip_packet_rx dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (LOCAL_IP),
        .ACCELERATOR_MAC_ADDRESS (LOCAL_MAC),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .RECEIVED_MESSAGE        (RECEIVED_MESSAGE),
        .MESSAGE_VALID           (MESSAGE_VALID),
        .MESSAGE_ACK             (MESSAGE_ACK)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Builds a well-formed frame of len bytes (truncated if shorter than headers+payload)
    task automatic build_frame(input logic [47:0] dmac, input logic [47:0] smac,
                               input logic [31:0] sip, input logic [31:0] dip,
                               input logic [7:0] p0, input logic [7:0] p1, input int len);
        logic [31:0] acc;
        logic [15:0] ip_len;
        ip_len  = 16'(len - 14);
        frame_q = {};
        for (int i = 5; i >= 0; i--) frame_q.push_back(dmac[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) frame_q.push_back(smac[i*8 +: 8]);
        frame_q.push_back(8'h08);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h45);
        frame_q.push_back(8'h00);
        frame_q.push_back(ip_len[15:8]);
        frame_q.push_back(ip_len[7:0]);
        frame_q.push_back(8'($urandom_range(0, 255)));
        frame_q.push_back(8'($urandom_range(0, 255)));
        frame_q.push_back(8'h40);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h40);
        frame_q.push_back(8'h11);
        frame_q.push_back(8'h00);
        frame_q.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frame_q.push_back(sip[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frame_q.push_back(dip[i*8 +: 8]);
        acc = 32'd0;
        for (int k = 0; k < 10; k++) acc = acc + 32'({frame_q[14+2*k], frame_q[15+2*k]});
        while (acc[31:16] != 16'd0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
        frame_q[24] = ~acc[15:8];
        frame_q[25] = ~acc[7:0];
        frame_q.push_back(p0);
        frame_q.push_back(p1);
        while (frame_q.size() < len) frame_q.push_back(8'($urandom_range(0, 255)));
        while (frame_q.size() > len) void'(frame_q.pop_back());
    endtask

    // Acceptance rule stated over the whole frame
    function automatic bit model_accepts(input bit tuser);
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [31:0] acc;
        if (tuser || frame_q.size() < 36) return 1'b0;
        dmac = '0;
        dip  = '0;
        acc  = '0;
        for (int i = 0; i < 6; i++) dmac = {dmac[39:0], frame_q[i]};
        for (int i = 30; i < 34; i++) dip = {dip[23:0], frame_q[i]};
        for (int k = 0; k < 10; k++) acc = acc + 32'({frame_q[14+2*k], frame_q[15+2*k]});
        while (acc[31:16] != 16'd0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
        return ((dmac == LOCAL_MAC) || (dmac == BCAST_MAC))
            && (frame_q[12] == 8'h08) && (frame_q[13] == 8'h00)
            && (frame_q[14] == 8'h45) && (dip == LOCAL_IP)
            && (acc[15:0] == 16'hFFFF);
    endfunction

    // Called at a negedge; returns at the negedge following the accepted beat
    task automatic drive_byte(input logic [7:0] d, input bit last, input bit tuser);
        int budget;
        budget         = 2000;
        MAC_DATA_IN    = d;
        MAC_DATA_VALID = 1'b1;
        MAC_DATA_LAST  = last;
        MAC_DATA_TUSER = last ? tuser : 1'($urandom_range(0, 1));
        while (!MAC_DATA_READY && budget > 0) begin
            @(negedge ACLK);
            budget--;
        end
        if (budget == 0) check("ready_timeout", 64'(MAC_DATA_READY), 64'd1);
        @(negedge ACLK);
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
    endtask

    task automatic send_bytes(input int count, input bit tuser, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            if (gap_pct > 0) begin
                while ($urandom_range(0, 99) < gap_pct) @(negedge ACLK);
            end
            drive_byte(frame_q[i], i == frame_q.size() - 1, tuser);
        end
    endtask

    task automatic expect_commit(input string tag, input bit tuser);
        bit acc;
        acc = model_accepts(tuser);
        check({tag, "_valid"}, 64'(MESSAGE_VALID), 64'(acc));
        if (acc) begin
            exp_mac = {frame_q[6], frame_q[7], frame_q[8], frame_q[9], frame_q[10], frame_q[11]};
            exp_ip  = {frame_q[26], frame_q[27], frame_q[28], frame_q[29]};
            exp_msg = {frame_q[34][1:0], frame_q[35]};
            check({tag, "_ready_hold"}, 64'(MAC_DATA_READY), 64'd0);
        end
        check({tag, "_ip"},  64'(SENDER_IP_ADDRESS),  64'(exp_ip));
        check({tag, "_mac"}, 64'(SENDER_MAC_ADDRESS), 64'(exp_mac));
        check({tag, "_msg"}, 64'(RECEIVED_MESSAGE),   64'(exp_msg));
    endtask

    task automatic ack_message(input string tag);
        if (MESSAGE_VALID) begin
            MESSAGE_ACK = 1'b1;
            @(negedge ACLK);
            MESSAGE_ACK = 1'b0;
            check({tag, "_ack_valid"}, 64'(MESSAGE_VALID), 64'd0);
            check({tag, "_ack_ready"}, 64'(MAC_DATA_READY), 64'd1);
        end
    endtask

    task automatic run_frame(input string tag, input bit tuser, input int gap_pct);
        send_bytes(frame_q.size(), tuser, gap_pct);
        expect_commit(tag, tuser);
        ack_message(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARESET         = 1'b0;
        MAC_DATA_IN    = 8'h00;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        MESSAGE_ACK    = 1'b0;
        exp_ip  = '0;
        exp_mac = '0;
        exp_msg = '0;
        repeat (3) @(negedge ACLK);
        check("rst_valid", 64'(MESSAGE_VALID), 64'd0);
        check("rst_ready", 64'(MAC_DATA_READY), 64'd1);
        check("rst_ip",    64'(SENDER_IP_ADDRESS), 64'd0);
        check("rst_mac",   64'(SENDER_MAC_ADDRESS), 64'd0);
        check("rst_msg",   64'(RECEIVED_MESSAGE), 64'd0);
        ARESET = 1'b1;
        @(negedge ACLK);

        // Basic 60-byte frame from the peer
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h02, 8'h5A, 60);
        send_bytes(frame_q.size(), 1'b0, 0);
        check("basic_msg_const", 64'(RECEIVED_MESSAGE), 64'h25A);
        check("basic_ip_const",  64'(SENDER_IP_ADDRESS), 64'h0A00_0001);
        expect_commit("basic", 1'b0);
        ack_message("basic");

        // Corrupted checksum byte, then a good frame
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h01, 8'h11, 60);
        frame_q[24] = ~frame_q[24];
        run_frame("bad_cks", 1'b0, 0);
        build_frame(LOCAL_MAC, PEER_MAC, 32'h0A00_0005, LOCAL_IP, 8'h03, 8'hC7, 60);
        run_frame("after_cks", 1'b0, 0);

        // Wrong destination IP, then broadcast MAC to the local IP
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, 32'h0A00_0003, 8'h02, 8'h77, 60);
        run_frame("wrong_ip", 1'b0, 0);
        build_frame(BCAST_MAC, 48'h02_00_00_00_00_09, 32'h0A00_0009, LOCAL_IP, 8'hFE, 8'h01, 60);
        run_frame("bcast", 1'b0, 0);

        // Frame error flag, truncated frame, then a good frame
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h01, 8'h99, 60);
        run_frame("tuser", 1'b1, 0);
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h01, 8'h99, 21);
        run_frame("trunc20", 1'b0, 0);
        build_frame(LOCAL_MAC, PEER_MAC, 32'h0A00_0011, LOCAL_IP, 8'h00, 8'h42, 60);
        run_frame("after_trunc", 1'b0, 0);

        // Payload boundary: one byte rejected, exactly two accepted
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h03, 8'h33, 35);
        run_frame("pay1", 1'b0, 0);
        build_frame(LOCAL_MAC, 48'h02_00_00_00_00_0A, 32'h0A00_0021, LOCAL_IP, 8'h01, 8'hA5, 36);
        run_frame("pay2", 1'b0, 0);

        // Gapped frame held while a second frame is already waiting
        build_frame(LOCAL_MAC, PEER_MAC, 32'h0A00_0031, LOCAL_IP, 8'h01, 8'h23, 60);
        send_bytes(frame_q.size(), 1'b0, 30);
        expect_commit("hold_a", 1'b0);
        build_frame(LOCAL_MAC, 48'h02_00_00_00_00_0B, 32'h0A00_0032, LOCAL_IP, 8'h03, 8'hC4, 60);
        fork
            send_bytes(frame_q.size(), 1'b0, 30);
            begin
                repeat (20) begin
                    @(negedge ACLK);
                    check("hold_ready", 64'(MAC_DATA_READY), 64'd0);
                    check("hold_msg_stable", 64'(RECEIVED_MESSAGE), 64'(exp_msg));
                end
                MESSAGE_ACK = 1'b1;
                @(negedge ACLK);
                MESSAGE_ACK = 1'b0;
            end
        join
        expect_commit("hold_b", 1'b0);
        ack_message("hold_b");

        // Asynchronous reset in the middle of the IP header
        build_frame(LOCAL_MAC, PEER_MAC, PEER_IP, LOCAL_IP, 8'h02, 8'h5A, 60);
        send_bytes(22, 1'b0, 0);
        #2 ARESET = 1'b0;
        #1;
        check("midrst_valid", 64'(MESSAGE_VALID), 64'd0);
        check("midrst_ready", 64'(MAC_DATA_READY), 64'd1);
        check("midrst_ip",    64'(SENDER_IP_ADDRESS), 64'd0);
        check("midrst_mac",   64'(SENDER_MAC_ADDRESS), 64'd0);
        check("midrst_msg",   64'(RECEIVED_MESSAGE), 64'd0);
        exp_ip  = '0;
        exp_mac = '0;
        exp_msg = '0;
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        build_frame(LOCAL_MAC, PEER_MAC, 32'h0A00_0041, LOCAL_IP, 8'h02, 8'h5B, 60);
        run_frame("after_rst", 1'b0, 0);

        // Randomized frames with assorted defects
        for (int n = 0; n < 24; n++) begin
            kind   = int'($urandom_range(0, 9));
            flen   = int'($urandom_range(36, 64));
            ftuser = 1'b0;
            r_dmac = LOCAL_MAC;
            r_dip  = LOCAL_IP;
            case (kind)
                1: r_dmac = BCAST_MAC;
                2: r_dmac = {16'h0200, 32'($urandom)};
                3: r_dip  = 32'($urandom);
                4: ftuser = 1'b1;
                5: flen   = int'($urandom_range(14, 35));
                default: ;
            endcase
            build_frame(r_dmac, {16'h0200, 32'($urandom)}, 32'($urandom), r_dip,
                        8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), flen);
            case (kind)
                6: frame_q[12] = 8'h86;
                7: frame_q[14] = 8'h46;
                8: frame_q[20] = frame_q[20] ^ 8'h10;
                default: ;
            endcase
            run_frame("rand", ftuser, 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ip_packet_rx.md
IP_PACKET_RX -- requirements
Module: ip_packet_rx

Interface
REQ-001 SHALL have parameter AXI_S_DATA_WIDTH, 8, MAC stream byte width.
REQ-002 SHALL have parameter IP_ADDR_WIDTH, 32, IPv4 address width.
REQ-003 SHALL have parameter MAC_ADDR_WIDTH, 48, Ethernet address width.
REQ-004 SHALL have parameter ACCEL_DATA_WIDTH, 10, delivered message width.
REQ-005 SHALL have port ACLK, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port ARESET, input, 1, asynchronous, active-low reset.
REQ-007 SHALL have port ACCELERATOR_IP_ADDRESS, input, 32, local IP used for filtering.
REQ-008 SHALL have port ACCELERATOR_MAC_ADDRESS, input, 48, local MAC used for filtering.
REQ-009 SHALL have port MAC_DATA_IN, input, 8, received byte, MSB-first per header field.
REQ-010 SHALL have port MAC_DATA_VALID, input, 1, byte valid.
REQ-011 SHALL have port MAC_DATA_READY, output, 1, block accepts byte; beat = VALID && READY.
REQ-012 SHALL have port MAC_DATA_LAST, input, 1, final byte of frame (FCS already stripped).
REQ-013 SHALL have port MAC_DATA_TUSER, input, 1, frame error flag, sampled on LAST beat.
REQ-014 SHALL have port SENDER_IP_ADDRESS, output, 32, source IP of accepted frame.
REQ-015 SHALL have port SENDER_MAC_ADDRESS, output, 48, source MAC of accepted frame.
REQ-016 SHALL have port RECEIVED_MESSAGE, output, 10, {payload byte0[1:0], payload byte1}.
REQ-017 SHALL have port MESSAGE_VALID, output, 1, accepted message held for accelerator.
REQ-018 SHALL have port MESSAGE_ACK, input, 1, accelerator consumed message.

Function
REQ-019 SHALL implement states RX_ETH_HDR, RX_IP_HDR, RX_USER_DATA, DROP, HOLD; byte counter advances one per beat, clears on every state change.
REQ-020 RX_ETH_HDR: bytes 0-5 destination MAC, 6-11 source MAC (captured), 12-13 ethertype; after byte 13 -> RX_IP_HDR, or -> DROP if any check failed.
REQ-021 Destination MAC SHALL match ACCELERATOR_MAC_ADDRESS or FF:FF:FF:FF:FF:FF; ethertype SHALL equal 0x0800.
REQ-022 RX_IP_HDR: 20 bytes; byte 0 SHALL equal 0x45; bytes 12-15 source IP (captured); bytes 16-19 SHALL equal ACCELERATOR_IP_ADDRESS; after byte 19 -> RX_USER_DATA or DROP.
REQ-023 Header checksum: 16-bit words from byte pairs added with end-around carry (17-bit accumulator); after byte 19 sum SHALL equal 0xFFFF, else DROP.
REQ-024 RX_USER_DATA: payload bytes 0-1 captured; counter saturates at 255; remaining bytes consumed and ignored.
REQ-025 On LAST beat in RX_USER_DATA with TUSER=0 and >=2 payload bytes: latch sender IP/MAC and message into output registers, -> HOLD; MESSAGE_VALID=1 the next cycle.
REQ-026 LAST beat in RX_ETH_HDR/RX_IP_HDR, LAST with <2 payload bytes, or TUSER=1: discard frame, -> RX_ETH_HDR, outputs unchanged.
REQ-027 DROP: READY=1, consume bytes until LAST beat, then -> RX_ETH_HDR; LAST on the byte that triggers DROP -> RX_ETH_HDR directly.
REQ-028 HOLD: READY=0, MESSAGE_VALID=1; MESSAGE_ACK -> RX_ETH_HDR with MESSAGE_VALID=0 next cycle.
REQ-029 READY SHALL be 1 in all states except HOLD; VALID=0 cycles SHALL stall counter and checksum without loss.
REQ-030 SENDER_*/RECEIVED_MESSAGE SHALL change only on commit (REQ-025); stable while MESSAGE_VALID=1.

Reset
REQ-031 ARESET=0 SHALL immediately force RX_ETH_HDR, counter 0, checksum 0, MESSAGE_VALID 0, all data outputs 0, including mid-frame; first post-reset byte is treated as frame byte 0.

Structure
REQ-032 Ethertype, header sizes, IP version byte and state enum SHALL reside in shared package ip_stack_pkg, also used by ip_packet_tx.
REQ-033 Checksum SHALL be sub-module ipv4_checksum_accumulator (clear, enable, byte-in, high/low select, 16-bit sum out); byte counter reuses counter_sync_reset.

Verification
REQ-034 Local MAC 02:00:00:00:00:02, IP 0x0A000002; valid 60-byte frame from 0x0A000001, payload 0x02,0x5A -> MESSAGE_VALID=1 one cycle after LAST, RECEIVED_MESSAGE=0x25A, SENDER_IP=0x0A000001.
REQ-035 Same frame with checksum byte flipped -> no MESSAGE_VALID; next valid frame accepted.
REQ-036 Destination IP 0x0A000003, then broadcast-MAC frame to 0x0A000002 -> first dropped, second accepted.
REQ-037 Valid frame, TUSER=1 on LAST -> discarded; frame truncated at byte 20 with LAST -> discarded, no hang.
REQ-038 Random VALID gaps plus second frame during HOLD -> READY=0 until MESSAGE_ACK, second frame then accepted intact.
REQ-039 ARESET pulsed at IP byte 7 -> all outputs 0; subsequent full frame accepted.
